load_store_unit: RTL

Multi-cycle load/store unit that executes the memory operations the instruction decoder describes with its MemWr / MemOp outputs. It accepts one request at a time from the execute stage (ALU-computed address plus rs2 store data) and serialises it onto a byte-wide valid/ready memory port. It returns sign- or zero-extended load data, or a fault, to the writeback path.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/load_extend.sv | 20 ++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Memory-operation encodings shared between the instruction decoder and the
// load/store unit, plus the LSU state type and request legality helpers.
package mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_BU = 3'b001;
  localparam logic [2:0] MEMOP_H  = 3'b010;
  localparam logic [2:0] MEMOP_HU = 3'b011;
  localparam logic [2:0] MEMOP_W  = 3'b100;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_RESP
  } lsu_state_e;

  // Unknown op, unsigned store, or access not naturally aligned.
  function automatic logic memop_illegal(input logic       wr,
                                         input logic [2:0] op,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (op > MEMOP_W)                       bad = 1'b1;
    if (wr && op[0])                        bad = 1'b1;
    if (op[2:1] == 2'b01 && addr_lo[0])     bad = 1'b1;
    if (op == MEMOP_W && addr_lo != 2'b00)  bad = 1'b1;
    return bad;
  endfunction

  // Index of the final byte beat for a legal op.
  function automatic logic [1:0] memop_last_beat(input logic [2:0] op);
    logic [1:0] last;
    case (op[2:1])
      2'b00:   last = 2'd0;
      2'b01:   last = 2'd1;
      default: last = 2'd3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled little-endian load data by MemOp.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    case (op_i)
      MEMOP_B:  ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      MEMOP_BU: ext_o = {24'd0, raw_i[7:0]};
      MEMOP_H:  ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      MEMOP_HU: ext_o = {16'd0, raw_i[15:0]};
      default:  ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time, serialised onto a
// byte-wide valid/ready memory port, with extended load data or fault back.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              busy,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              wr_q, wr_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        last_q, last_d;
  logic [31:0]       asm_q, asm_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic              beat_done;
  logic [1:0]        beat_nxt;
  logic [31:0]       asm_merged;
  logic [31:0]       load_ext;

  assign beat_done = mem_valid_q && mem_ready;
  assign beat_nxt  = beat_q + 2'd1;

  // Assembly register with the byte arriving this cycle already merged in, so
  // the response can be registered on the same edge the last beat completes.
  always_comb begin
    asm_merged = asm_q;
    asm_merged[{beat_q, 3'b000} +: 8] = mem_rdata;
  end

  load_extend u_load_extend (
    .op_i  (op_q),
    .raw_i (asm_merged),
    .ext_o (load_ext)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    wr_d        = wr_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    last_d      = last_q;
    asm_d       = asm_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_fault_d = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          op_d    = req_op;
          wdata_d = req_wdata;
          beat_d  = 2'd0;
          last_d  = memop_last_beat(req_op);
          asm_d   = 32'd0;
          if (memop_illegal(req_wr, req_op, req_addr[1:0])) begin
            state_d     = LSU_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else begin
            state_d     = LSU_ACCESS;
            mem_valid_d = 1'b1;
            mem_we_d    = req_wr;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata[7:0];
          end
        end
      end
      LSU_ACCESS: begin
        if (beat_done) begin
          if (!wr_q) asm_d = asm_merged;
          if (beat_q == last_q) begin
            state_d     = LSU_RESP;
            mem_valid_d = 1'b0;
            mem_we_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = wr_q ? 32'd0 : load_ext;
          end else begin
            beat_d      = beat_nxt;
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            mem_wdata_d = wdata_q[{beat_nxt, 3'b000} +: 8];
          end
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    if (rst) begin
      state_q     <= LSU_IDLE;
      wr_q        <= 1'b0;
      op_q        <= 3'd0;
      wdata_q     <= 32'd0;
      beat_q      <= 2'd0;
      last_q      <= 2'd0;
      asm_q       <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      asm_q       <= asm_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign req_ready = (state_q == LSU_IDLE);
  assign busy      = (state_q != LSU_IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
